// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI mode-0 master between NUM_REQ byte requesters.
// Each grant latches one byte and its slave index, then runs a single MSB-first frame.
module spi_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int NUM_SLV = 2,
    parameter int SLV_W   = 1,
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    input  logic [NUM_REQ*SLV_W-1:0]     req_slv,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         sclk,
    output logic                         mosi,
    output logic [NUM_SLV-1:0]           cs_n
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLK_DIV + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       half_q;
    logic [7:0]       shift_q;
    logic [SLV_W-1:0] slv_q;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    rr_ptr_q;

    logic             any_valid;
    logic [GW-1:0]    gnt;
    int               gnt_idx;
    int               idx;
    logic             cnt_last;
    logic             active;
    logic             accept;
    logic [GW-1:0]    next_ptr;

    // First valid requester at or after rr_ptr_q, wrapping around.
    always_comb begin
        any_valid = 1'b0;
        gnt       = '0;
        gnt_idx   = 0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                gnt       = GW'(idx);
                gnt_idx   = idx;
            end
        end
    end

    assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
    assign accept   = rst_n && (state_q == ST_IDLE) && any_valid;
    assign active   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign next_ptr = GW'((int'(grant_q) + 1) % NUM_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            half_q   <= '0;
            shift_q  <= '0;
            slv_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= '0;
                        grant_q <= gnt;
                        shift_q <= req_data[8*gnt_idx +: 8];
                        slv_q   <= req_slv[SLV_W*gnt_idx +: SLV_W];
                    end
                end
                ST_SETUP: begin
                    if (cnt_last) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                        half_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (half_q == 4'd15) begin
                            state_q <= ST_HOLD;
                        end else begin
                            half_q <= half_q + 1'b1;
                            // Leaving a high half-period is the falling edge: present next bit.
                            if (half_q[0]) shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_last) begin
                        state_q  <= ST_GAP;
                        cnt_q    <= '0;
                        rr_ptr_q <= next_ptr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    // Done cycle plus CLK_DIV deselect cycles.
                    if (cnt_q == CW'(CLK_DIV)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        done      = '0;
        cs_n      = '1;
        if (accept) req_ready = NUM_REQ'(1) << gnt;
        if (state_q == ST_GAP && cnt_q == '0) done = NUM_REQ'(1) << grant_q;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (active && int'(slv_q) == i) cs_n[i] = 1'b0;
        end
    end

    assign sclk     = (state_q == ST_SHIFT) && half_q[0];
    assign mosi     = active && shift_q[7];
    assign busy     = rst_n && ((state_q != ST_IDLE) || any_valid);
    assign grant_id = accept ? gnt : grant_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: vector table plus hand sequences, checked by a done-driven scoreboard.
// A second instance with a single slave covers the out-of-range slave index.
module tb_spi_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_valid = '0;
    logic [15:0] req_data  = '0;
    logic [1:0]  req_slv   = '0;
    logic [1:0]  req_ready, done, cs_n;
    logic        busy, sclk, mosi;
    logic [0:0]  grant_id;

    logic [1:0]  v1_valid = '0;
    logic [15:0] v1_data  = '0;
    logic [1:0]  v1_slv   = '0;
    logic [1:0]  r1_ready, r1_done;
    logic        r1_busy, r1_sclk, r1_mosi;
    logic [0:0]  r1_gid, r1_cs_n;

    spi_bus_arbiter #(.NUM_REQ(2), .NUM_SLV(2), .SLV_W(1), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_slv(req_slv), .req_ready(req_ready), .done(done), .busy(busy),
        .grant_id(grant_id), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
    );

    spi_bus_arbiter #(.NUM_REQ(2), .NUM_SLV(1), .SLV_W(1), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1_valid), .req_data(v1_data),
        .req_slv(v1_slv), .req_ready(r1_ready), .done(r1_done), .busy(r1_busy),
        .grant_id(r1_gid), .sclk(r1_sclk), .mosi(r1_mosi), .cs_n(r1_cs_n)
    );

    typedef struct { int id; logic [7:0] data; logic [1:0] mask; } exp_t;
    typedef struct { int id; logic [7:0] data; logic slv; logic [1:0] mask; } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          acc_cyc[$];
    int          acc_id[$];
    int          gap_runs[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          viol = 0;
    int          mon_nrise = 0;
    int          hi_run = 0;
    int          acc_t = 0;
    logic [7:0]  cap = '0;
    logic [1:0]  low_mask = '0;
    logic        sclk_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: captures accepts, bits on sclk rises, cs activity; scores each frame at done.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_nrise = 0;
            hi_run    = 0;
            sclk_prev = 1'b0;
            low_mask  = '0;
        end else begin
            if ($countones(req_ready) > 1 || (req_ready != 0 && done != 0) ||
                $countones(~cs_n) > 1) viol++;
            if (req_ready != 0) begin
                acc_t = cyc;
                acc_cyc.push_back(cyc);
                acc_id.push_back(req_ready[1] ? 1 : 0);
                cap       = '0;
                mon_nrise = 0;
                low_mask  = '0;
            end
            if (sclk && !sclk_prev) begin
                cap = {cap[6:0], mosi};
                mon_nrise++;
            end
            sclk_prev = sclk;
            low_mask  = low_mask | ~cs_n;
            if (cs_n == 2'b11) hi_run++;
            else begin
                if (hi_run > 0) gap_runs.push_back(hi_run);
                hi_run = 0;
            end
            if (done != 0) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: done=%b with no frame pending", done);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_id", 32'(done), 32'(2'b01 << mon_e.id));
                    check("grant_id", 32'(grant_id), 32'(mon_e.id));
                    check("mosi_byte", 32'(cap), 32'(mon_e.data));
                    check("sclk_rises", mon_nrise, 8);
                    check("done_latency", cyc - acc_t, 73);
                    check("cs_low_mask", 32'(low_mask), 32'(mon_e.mask));
                end
            end
        end
    end

    task automatic request(input int id, input logic [7:0] d, input logic s);
        @(posedge clk);
        #1;
        req_data[8*id +: 8] = d;
        req_slv[id]         = s;
        req_valid[id]       = 1'b1;
    endtask

    task automatic wait_accept(input int id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: requester %0d got no req_ready in 200 cycles", id);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d frames pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic int last_gap(input int dummy);
        return (gap_runs.size() > 0) ? gap_runs[gap_runs.size()-1] + dummy : -1;
    endfunction

    initial begin
        vec_t vecs[4];
        bit   ok;
        int   k;
        int   n;
        int   cs_bad;
        int   lat;

        vecs[0] = '{0, 8'hAA, 1'b1, 2'b10};
        vecs[1] = '{1, 8'h5A, 1'b0, 2'b01};
        vecs[2] = '{0, 8'h3C, 1'b0, 2'b01};
        vecs[3] = '{1, 8'hC3, 1'b1, 2'b10};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_cs_n", 32'(cs_n), 32'(2'b11));
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        #19 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single transfers from the vector table
        for (int i = 0; i < 4; i++) begin
            request(vecs[i].id, vecs[i].data, vecs[i].slv);
            sb.push_back('{vecs[i].id, vecs[i].data, vecs[i].mask});
            wait_accept(vecs[i].id, ok);
            if (ok) check("busy_at_accept", 32'(busy), 1);
            @(posedge clk);
            #1 req_valid[vecs[i].id] = 1'b0;
            @(negedge clk);
            check("ready_one_cycle", 32'(req_ready), 0);
            drain(200);
        end

        // Simultaneous requests: req0 then req1, 78 cycles apart
        @(posedge clk);
        #1;
        req_data  = {8'hC3, 8'h3C};
        req_slv   = 2'b10;
        req_valid = 2'b11;
        sb.push_back('{0, 8'h3C, 2'b01});
        sb.push_back('{1, 8'hC3, 2'b10});
        n = acc_cyc.size();
        wait_accept(0, ok);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_accept(1, ok);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        drain(200);
        check("simul_accepts", acc_cyc.size() - n, 2);
        if (acc_cyc.size() - n == 2) begin
            check("simul_spacing", acc_cyc[n+1] - acc_cyc[n], 78);
            check("simul_order", acc_id[n], 0);
        end

        // Fairness: both held valid for four frames
        @(posedge clk);
        #1;
        req_data  = {8'h22, 8'h11};
        req_slv   = 2'b10;
        req_valid = 2'b11;
        n = acc_id.size();
        for (int j = 0; j < 4; j++) sb.push_back('{j % 2, (j % 2 == 0) ? 8'h11 : 8'h22,
                                                   (j % 2 == 0) ? 2'b01 : 2'b10});
        for (int j = 0; j < 4; j++) wait_accept(j % 2, ok);
        @(posedge clk);
        #1 req_valid = 2'b00;
        drain(400);
        check("fair_accepts", acc_id.size() - n, 4);
        if (acc_id.size() - n == 4) begin
            for (int j = 0; j < 4; j++) check("fair_grant_order", acc_id[n+j], j % 2);
        end

        // Reset in the middle of SHIFT, while bit 3 is being prepared
        request(1, 8'hD9, 1'b1);
        wait_accept(1, ok);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        k = 0;
        while (mon_nrise < 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_rise4", mon_nrise, 4);
        @(negedge clk);
        #2;
        check("pre_abort_cs_n", 32'(cs_n), 32'(2'b01));
        check("pre_abort_sclk", 32'(sclk), 1);
        check("pre_abort_mosi", 32'(mosi), 1);
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n), 32'(2'b11));
        check("abort_sclk", 32'(sclk), 0);
        check("abort_mosi", 32'(mosi), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_grant", 32'(grant_id), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        request(1, 8'h5A, 1'b0);
        sb.push_back('{1, 8'h5A, 2'b01});
        wait_accept(1, ok);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        drain(200);

        // Back-to-back on requester 1 with valid held
        request(1, 8'hFF, 1'b1);
        sb.push_back('{1, 8'hFF, 2'b10});
        sb.push_back('{1, 8'h00, 2'b10});
        n = acc_cyc.size();
        wait_accept(1, ok);
        @(posedge clk);
        #1 req_data[15:8] = 8'h00;
        wait_accept(1, ok);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        drain(300);
        check("b2b_accepts", acc_cyc.size() - n, 2);
        if (acc_cyc.size() - n == 2) check("b2b_spacing", acc_cyc[n+1] - acc_cyc[n], 78);
        check("b2b_cs_gap", last_gap(0), 6);

        // Out-of-range slave on the single-slave instance
        @(posedge clk);
        #1;
        v1_data[7:0] = 8'h81;
        v1_slv[0]    = 1'b1;
        v1_valid[0]  = 1'b1;
        ok = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (r1_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("oor_accept", 32'(ok), 1);
        @(posedge clk);
        #1 v1_valid[0] = 1'b0;
        cs_bad = 0;
        lat    = -1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (r1_cs_n != 1'b1) cs_bad++;
            if (r1_done[0]) begin
                lat = j;
                break;
            end
        end
        check("oor_cs_never_low", cs_bad, 0);
        check("oor_done_latency", lat, 73);

        check("invariants", viol, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
